// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory between an instruction-fetch port and a
//   data port. A grant walks IDLE -> ACCESS (MEM_LATENCY strobe cycles) ->
//   RESP (one-cycle ack) -> IDLE.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   : ties go to the port not served by the last grant
//                  undefined : ties always go to the data port
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_req/i_addr               fetch request (always a read)
//   i_ack/i_rdata              fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata  data request
//   d_ack/d_rdata              data completion pulse and read word
//   mem_read/mem_write         memory strobes (mutually exclusive)
//   mem_addr/mem_wdata         latched address / write data
//   mem_rdata                  memory read data, valid in the last strobe cycle
//   busy                       state is not IDLE
//   owner                      current or last grant: 0 = fetch, 1 = data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned WORD_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic              i_ack,
  output logic [WORD_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [WORD_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_data_s;
`ifdef MEM_ARB_RR_EN
  logic              last_q, last_d;  // 1 = data port was served last
`endif

  // Arbitration decision for a request sampled in IDLE.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On a tie, data wins only if fetch was served last.
    grant_data_s = d_req & (~i_req | ~last_q);
`else
    grant_data_s = d_req;
`endif
  end

  // State register and latched transaction fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  // Next-state logic: grant in IDLE, count down ACCESS, capture read data.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          state_d = ACCESS;
          cnt_d   = 4'(MEM_LATENCY - 1);
          owner_d = grant_data_s;
          // Fetch grants are always reads, whatever d_we says.
          we_d    = grant_data_s & d_we;
          addr_d  = grant_data_s ? d_addr : i_addr;
          wdata_d = grant_data_s ? d_wdata : '0;
`ifdef MEM_ARB_RR_EN
          last_d  = grant_data_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          // Last strobe cycle: read data is valid now.
          if (!we_q) begin
            if (owner_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              i_rdata_d = mem_rdata;
            end
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    mem_read  = (state_q == ACCESS) & ~we_q;
    mem_write = (state_q == ACCESS) & we_q;
    i_ack     = (state_q == RESP) & ~owner_q;
    d_ack     = (state_q == RESP) & owner_q;
    busy      = (state_q != IDLE);
    owner     = owner_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule
